// File: rtl/mc_ctrl_if.sv
// mc_ctrl_if: IR/ALU-flag/memory-ack inputs and the datapath control outputs of the multi-cycle controller.
interface mc_ctrl_if #(parameter int CNT_W = 32);
    logic [31:0]      instr;
    logic             alu_zero;
    logic             mem_ready;
    logic [3:0]       state;
    logic             pc_write;
    logic [1:0]       pc_src;
    logic             ir_write;
    logic             mem_read;
    logic             mem_write;
    logic             reg_write;
    logic [1:0]       reg_dst;
    logic [1:0]       mem_to_reg;
    logic [1:0]       alu_src_a;
    logic [1:0]       alu_src_b;
    logic             ext_op;
    logic [4:0]       alu_op;
    logic             illegal;
    logic [CNT_W-1:0] instret;

    modport master (
        input  instr, alu_zero, mem_ready,
        output state, pc_write, pc_src, ir_write, mem_read, mem_write, reg_write,
               reg_dst, mem_to_reg, alu_src_a, alu_src_b, ext_op, alu_op, illegal, instret
    );
    modport slave (
        output instr, alu_zero, mem_ready,
        input  state, pc_write, pc_src, ir_write, mem_read, mem_write, reg_write,
               reg_dst, mem_to_reg, alu_src_a, alu_src_b, ext_op, alu_op, illegal, instret
    );
endinterface

// File: rtl/mc_ctrl.sv
// mc_ctrl: multi-cycle MIPS control FSM stepping each instruction through fetch/decode/exec/mem/wb.
module mc_ctrl #(
    parameter bit TRAP_ON_ILLEGAL = 1'b1,
    parameter int CNT_W           = 32
) (
    input logic        clk,
    input logic        rst_n,
    mc_ctrl_if.master  bus_io
);
    localparam logic [4:0] A_NOP = 5'd0,  A_LUI = 5'd1,  A_ADD = 5'd2,  A_SUB = 5'd3,
                           A_AND = 5'd4,  A_OR  = 5'd5,  A_XOR = 5'd6,  A_NOR = 5'd7,
                           A_SLT = 5'd8,  A_SLTU = 5'd9, A_SLL = 5'd10, A_SRL = 5'd11,
                           A_SRA = 5'd12, A_BEQ = 5'd13, A_BNE = 5'd14, A_ADDU = 5'd15,
                           A_SUBU = 5'd16;

    typedef enum logic [3:0] {
        FETCH, DECODE, EXEC_R, EXEC_I, WB_ALU, MEM_ADDR, MEM_RD, WB_MEM, MEM_WR, BRANCH, JUMP, TRAP
    } state_t;

    state_t           state_q, state_d;
    logic             illegal_q, illegal_d;
    logic [CNT_W-1:0] instret_q, instret_d;

    logic [5:0] op, fn;
    logic [4:0] r_op, i_op;
    logic       r_ok, shift, jr, ext;
    logic       is_r, is_i, is_mem, is_br, is_j, legal;
    logic       pcw, irw, mrd, mwr, rgw, ret;

    assign op     = bus_io.instr[31:26];
    assign fn     = bus_io.instr[5:0];
    assign is_r   = op == 6'h00;
    assign is_i   = op[5:3] == 3'b001;
    assign is_mem = op == 6'h23 || op == 6'h2B;
    assign is_br  = op == 6'h04 || op == 6'h05;
    assign is_j   = op == 6'h02 || op == 6'h03;
    assign legal  = is_r ? r_ok : (is_i | is_mem | is_br | is_j);

    always_comb begin
        r_op  = A_NOP;
        r_ok  = 1'b1;
        shift = 1'b0;
        jr    = 1'b0;
        case (fn)
            6'h20: r_op = A_ADD;
            6'h21: r_op = A_ADDU;
            6'h22: r_op = A_SUB;
            6'h23: r_op = A_SUBU;
            6'h24: r_op = A_AND;
            6'h25: r_op = A_OR;
            6'h26: r_op = A_XOR;
            6'h27: r_op = A_NOR;
            6'h2A: r_op = A_SLT;
            6'h2B: r_op = A_SLTU;
            6'h00: begin r_op = A_SLL; shift = 1'b1; end
            6'h02: begin r_op = A_SRL; shift = 1'b1; end
            6'h03: begin r_op = A_SRA; shift = 1'b1; end
            6'h04: r_op = A_SLL;
            6'h06: r_op = A_SRL;
            6'h07: r_op = A_SRA;
            6'h08: jr = 1'b1;
            default: r_ok = 1'b0;
        endcase
        i_op = A_NOP;
        ext  = 1'b1;
        case (op)
            6'h08: i_op = A_ADD;
            6'h09: i_op = A_ADDU;
            6'h0A: i_op = A_SLT;
            6'h0B: i_op = A_SLTU;
            6'h0C: begin i_op = A_AND; ext = 1'b0; end
            6'h0D: begin i_op = A_OR;  ext = 1'b0; end
            6'h0E: begin i_op = A_XOR; ext = 1'b0; end
            6'h0F: i_op = A_LUI;
            default: ;
        endcase
    end

    always_comb begin
        state_d           = state_q;
        illegal_d         = illegal_q;
        ret               = 1'b0;
        pcw               = 1'b0;
        irw               = 1'b0;
        mrd               = 1'b0;
        mwr               = 1'b0;
        rgw               = 1'b0;
        bus_io.pc_src     = 2'b00;
        bus_io.reg_dst    = 2'b00;
        bus_io.mem_to_reg = 2'b00;
        bus_io.alu_src_a  = 2'b00;
        bus_io.alu_src_b  = 2'b00;
        bus_io.ext_op     = 1'b1;
        bus_io.alu_op     = A_NOP;
        case (state_q)
            FETCH: begin
                mrd              = 1'b1;
                bus_io.alu_src_b = 2'b01;
                bus_io.alu_op    = A_ADD;
                irw              = bus_io.mem_ready;
                pcw              = bus_io.mem_ready;
                state_d          = bus_io.mem_ready ? DECODE : FETCH;
            end
            DECODE: begin
                bus_io.alu_src_b = 2'b11;
                bus_io.alu_op    = A_ADD;
                state_d = !legal ? (TRAP_ON_ILLEGAL ? TRAP : FETCH) :
                          is_r   ? (jr ? JUMP : EXEC_R) :
                          is_i   ? EXEC_I :
                          is_mem ? MEM_ADDR :
                          is_br  ? BRANCH : JUMP;
                illegal_d = illegal_q | (!legal & TRAP_ON_ILLEGAL);
                ret       = !legal & !TRAP_ON_ILLEGAL;
            end
            EXEC_R: begin
                bus_io.alu_src_a = shift ? 2'b10 : 2'b01;
                bus_io.alu_op    = r_op;
                state_d          = WB_ALU;
            end
            EXEC_I: begin
                bus_io.alu_src_a = 2'b01;
                bus_io.alu_src_b = 2'b10;
                bus_io.ext_op    = ext;
                bus_io.alu_op    = i_op;
                state_d          = WB_ALU;
            end
            WB_ALU: begin
                rgw            = 1'b1;
                bus_io.reg_dst = is_r ? 2'b01 : 2'b00;
                state_d        = FETCH;
                ret            = 1'b1;
            end
            MEM_ADDR: begin
                bus_io.alu_src_a = 2'b01;
                bus_io.alu_src_b = 2'b10;
                bus_io.alu_op    = A_ADD;
                state_d          = op == 6'h23 ? MEM_RD : MEM_WR;
            end
            MEM_RD: begin
                mrd     = 1'b1;
                state_d = bus_io.mem_ready ? WB_MEM : MEM_RD;
            end
            WB_MEM: begin
                rgw               = 1'b1;
                bus_io.mem_to_reg = 2'b01;
                state_d           = FETCH;
                ret               = 1'b1;
            end
            MEM_WR: begin
                mwr     = 1'b1;
                state_d = bus_io.mem_ready ? FETCH : MEM_WR;
                ret     = bus_io.mem_ready;
            end
            BRANCH: begin
                bus_io.alu_src_a = 2'b01;
                bus_io.alu_op    = op[0] ? A_BNE : A_BEQ;
                bus_io.pc_src    = 2'b01;
                pcw              = bus_io.alu_zero;
                state_d          = FETCH;
                ret              = 1'b1;
            end
            JUMP: begin
                pcw               = 1'b1;
                bus_io.pc_src     = is_r ? 2'b11 : 2'b10;
                rgw               = op == 6'h03;
                bus_io.reg_dst    = op == 6'h03 ? 2'b10 : 2'b00;
                bus_io.mem_to_reg = op == 6'h03 ? 2'b10 : 2'b00;
                state_d           = FETCH;
                ret               = 1'b1;
            end
            TRAP: ;
            default: state_d = FETCH;
        endcase
        instret_d = instret_q + CNT_W'(ret);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= FETCH;
            illegal_q <= 1'b0;
            instret_q <= '0;
        end else begin
            state_q   <= state_d;
            illegal_q <= illegal_d;
            instret_q <= instret_d;
        end
    end

    // Reset overrides every strobe so an aborted instruction writes nothing.
    assign bus_io.pc_write  = pcw & rst_n;
    assign bus_io.ir_write  = irw & rst_n;
    assign bus_io.mem_read  = mrd & rst_n;
    assign bus_io.mem_write = mwr & rst_n;
    assign bus_io.reg_write = rgw & rst_n;
    assign bus_io.state     = state_q;
    assign bus_io.illegal   = illegal_q;
    assign bus_io.instret   = instret_q;
endmodule

// File: tb/tb_mc_ctrl.sv
// tb_mc_ctrl: directed scoreboard bench; each queued record drives one cycle's inputs and its expected outputs.
module tb_mc_ctrl;
    localparam logic [4:0] A_LUI = 5'd1, A_ADD = 5'd2, A_OR = 5'd5, A_SLL = 5'd10,
                           A_BEQ = 5'd13, A_BNE = 5'd14;
    localparam logic [3:0] S_FETCH = 4'd0, S_DECODE = 4'd1, S_EXEC_R = 4'd2, S_EXEC_I = 4'd3,
                           S_WB_ALU = 4'd4, S_MEM_ADDR = 4'd5, S_MEM_RD = 4'd6, S_WB_MEM = 4'd7,
                           S_MEM_WR = 4'd8, S_BRANCH = 4'd9, S_JUMP = 4'd10, S_TRAP = 4'd11;

    typedef struct {
        logic        rst, mr, az;
        logic [3:0]  st;
        logic [5:0]  stb;
        logic [15:0] sel, msk;
        logic [31:0] cnt;
        logic        c0;
        logic [3:0]  s0;
        logic [31:0] n0;
    } rec_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] instr;
    logic        alu_zero, mem_ready;
    int          n_asrt = 0, n_fail = 0;
    logic [31:0] cnt;
    logic        ill;
    rec_t        q[$];

    mc_ctrl_if #(.CNT_W(32)) b1 ();
    mc_ctrl_if #(.CNT_W(32)) b0 ();
    assign b1.instr = instr;
    assign b0.instr = instr;
    assign b1.alu_zero = alu_zero;
    assign b0.alu_zero = alu_zero;
    assign b1.mem_ready = mem_ready;
    assign b0.mem_ready = mem_ready;

    mc_ctrl #(.TRAP_ON_ILLEGAL(1'b1), .CNT_W(32)) dut1 (.clk(clk), .rst_n(rst_n), .bus_io(b1));
    mc_ctrl #(.TRAP_ON_ILLEGAL(1'b0), .CNT_W(32)) dut0 (.clk(clk), .rst_n(rst_n), .bus_io(b0));

    always #5 clk = ~clk;

    function automatic logic [15:0] sf(input logic [1:0] ps, rd, mt, sa, sb, input logic ex, input logic [4:0] op);
        return {ps, rd, mt, sa, sb, ex, op};
    endfunction

    task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
        n_asrt++;
        assert (o === e) else begin
            n_fail++;
            $error("FAIL %s: got %0h expected %0h", tag, o, e);
        end
    endtask

    task automatic push(input logic rst, mr, az, input logic [3:0] st, input logic [5:0] stb,
                        input logic [15:0] sl, mk, input logic c0, input logic [3:0] s0, input logic [31:0] n0);
        rec_t r;
        r.rst = rst; r.mr = mr; r.az = az; r.st = st; r.stb = stb; r.sel = sl; r.msk = mk;
        r.cnt = cnt; r.c0 = c0; r.s0 = s0; r.n0 = n0;
        q.push_back(r);
    endtask

    task automatic fetch(input logic mr);
        push(1, mr, 0, S_FETCH, {mr, mr, 1'b1, 1'b0, 1'b0, ill}, sf(0, 0, 0, 0, 1, 0, A_ADD),
             sf(mr ? 2'b11 : 2'b00, 0, 0, 3, 3, 0, 5'h1f), 0, 0, 0);
    endtask
    task automatic decode();
        push(1, 1, 0, S_DECODE, {5'b0, ill}, sf(0, 0, 0, 0, 3, 0, A_ADD), sf(0, 0, 0, 3, 3, 0, 5'h1f), 0, 0, 0);
    endtask
    task automatic exec_r(input logic [4:0] op, input logic sh);
        push(1, 1, 0, S_EXEC_R, {5'b0, ill}, sf(0, 0, 0, sh ? 2'd2 : 2'd1, 0, 0, op), sf(0, 0, 0, 3, 3, 0, 5'h1f), 0, 0, 0);
    endtask
    task automatic exec_i(input logic [4:0] op, input logic ex, input logic exm);
        push(1, 1, 0, S_EXEC_I, {5'b0, ill}, sf(0, 0, 0, 1, 2, ex, op), sf(0, 0, 0, 3, 3, exm, 5'h1f), 0, 0, 0);
    endtask
    task automatic wb_alu(input logic r);
        push(1, 1, 0, S_WB_ALU, {4'b0, 1'b1, ill}, sf(0, r ? 2'd1 : 2'd0, 0, 0, 0, 0, 0), sf(0, 3, 3, 0, 0, 0, 0), 0, 0, 0);
        cnt++;
    endtask
    task automatic mem_addr();
        push(1, 1, 0, S_MEM_ADDR, {5'b0, ill}, sf(0, 0, 0, 1, 2, 1, A_ADD), sf(0, 0, 0, 3, 3, 1, 5'h1f), 0, 0, 0);
    endtask
    task automatic mem_rd(input logic mr);
        push(1, mr, 0, S_MEM_RD, {2'b0, 1'b1, 2'b0, ill}, 0, 0, 0, 0, 0);
    endtask
    task automatic wb_mem();
        push(1, 1, 0, S_WB_MEM, {4'b0, 1'b1, ill}, sf(0, 0, 1, 0, 0, 0, 0), sf(0, 3, 3, 0, 0, 0, 0), 0, 0, 0);
        cnt++;
    endtask
    task automatic mem_wr(input logic mr);
        push(1, mr, 0, S_MEM_WR, {3'b0, 1'b1, 1'b0, ill}, 0, 0, 0, 0, 0);
        if (mr) cnt++;
    endtask
    task automatic branch(input logic az, input logic bne);
        push(1, 1, az, S_BRANCH, {az, 4'b0, ill}, sf(1, 0, 0, 1, 0, 0, bne ? A_BNE : A_BEQ),
             sf(3, 0, 0, 3, 3, 0, 5'h1f), 0, 0, 0);
        cnt++;
    endtask
    task automatic jump(input logic jal, input logic jr);
        push(1, 1, 0, S_JUMP, {1'b1, 3'b0, jal, ill}, sf(jr ? 2'd3 : 2'd2, jal ? 2'd2 : 2'd0, jal ? 2'd2 : 2'd0, 0, 0, 0, 0),
             sf(3, jal ? 2'd3 : 2'd0, jal ? 2'd3 : 2'd0, 0, 0, 0, 0), 0, 0, 0);
        cnt++;
    endtask
    task automatic trap();
        push(1, 1, 0, S_TRAP, 6'b000001, 0, 0, 0, 0, 0);
    endtask

    task automatic drain();
        rec_t r;
        while (q.size() > 0) begin
            r = q.pop_front();
            @(negedge clk);
            rst_n = r.rst; mem_ready = r.mr; alu_zero = r.az;
            #1;
            chk("state", 32'(b1.state), 32'(r.st));
            chk("strobes", 32'({b1.pc_write, b1.ir_write, b1.mem_read, b1.mem_write, b1.reg_write, b1.illegal}), 32'(r.stb));
            chk("instret", b1.instret, r.cnt);
            if (r.msk != 16'h0)
                chk("sel", 32'(sf(b1.pc_src, b1.reg_dst, b1.mem_to_reg, b1.alu_src_a, b1.alu_src_b, b1.ext_op, b1.alu_op) & r.msk),
                    32'(r.sel & r.msk));
            if (r.c0) begin
                chk("state0", 32'(b0.state), 32'(r.s0));
                chk("instret0", b0.instret, r.n0);
                chk("illegal0", 32'(b0.illegal), 32'h0);
            end
        end
        @(posedge clk);
    endtask

    initial begin
        rst_n = 1'b0; mem_ready = 1'b0; alu_zero = 1'b0; instr = 32'h0; cnt = 0; ill = 1'b0;
        repeat (2) @(posedge clk);
        push(0, 0, 0, S_FETCH, 6'b0, 0, 0, 1, S_FETCH, 0);
        drain();
        instr = 32'h00221820;
        fetch(1); decode(); exec_r(A_ADD, 0); wb_alu(1); drain();
        instr = 32'h00021080;
        fetch(1); decode(); exec_r(A_SLL, 1); wb_alu(1); drain();
        instr = 32'h00431004;
        fetch(1); decode(); exec_r(A_SLL, 0); wb_alu(1); drain();
        instr = 32'h34220005;
        fetch(1); decode(); exec_i(A_OR, 0, 1); wb_alu(0); drain();
        instr = 32'h20220005;
        fetch(1); decode(); exec_i(A_ADD, 1, 1); wb_alu(0); drain();
        instr = 32'h3C011234;
        fetch(1); decode(); exec_i(A_LUI, 0, 0); wb_alu(0); drain();
        instr = 32'h10220004;
        fetch(1); decode(); branch(1, 0); fetch(1); decode(); branch(0, 0); drain();
        instr = 32'h14220004;
        fetch(1); decode(); branch(1, 1); drain();
        instr = 32'h8C050008;
        fetch(0); fetch(0); fetch(1); decode(); mem_addr();
        mem_rd(0); mem_rd(0); mem_rd(0); mem_rd(1); wb_mem(); drain();
        instr = 32'hAC050008;
        fetch(1); decode(); mem_addr(); mem_wr(0); mem_wr(1); drain();
        instr = 32'h0C000040;
        fetch(1); decode(); jump(1, 0); drain();
        instr = 32'h08000040;
        fetch(1); decode(); jump(0, 0); drain();
        instr = 32'h03E00008;
        fetch(1); decode(); jump(0, 1); drain();
        instr = 32'hFC000000;
        fetch(1); decode(); ill = 1'b1;
        push(1, 1, 0, S_TRAP, 6'b000001, 0, 0, 1, S_FETCH, cnt + 1);
        trap(); trap();
        push(0, 1, 0, S_TRAP, 6'b000001, 0, 0, 0, 0, 0);
        ill = 1'b0; cnt = 0;
        push(1, 0, 0, S_FETCH, 6'b001000, 0, 0, 1, S_FETCH, 0);
        drain();
        instr = 32'h00000001;
        fetch(1); decode(); ill = 1'b1;
        push(1, 1, 0, S_TRAP, 6'b000001, 0, 0, 1, S_FETCH, cnt + 1);
        push(0, 1, 0, S_TRAP, 6'b000001, 0, 0, 0, 0, 0);
        ill = 1'b0; cnt = 0;
        push(1, 0, 0, S_FETCH, 6'b001000, 0, 0, 1, S_FETCH, 0);
        drain();
        instr = 32'h00221820;
        fetch(1); decode(); exec_r(A_ADD, 0); wb_alu(1); drain();
        instr = 32'hAC050008;
        fetch(1); decode(); mem_addr();
        push(0, 1, 0, S_MEM_WR, 6'b0, 0, 0, 0, 0, 0);
        cnt = 0;
        fetch(1);
        drain();
        $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
        $finish;
    end
endmodule
